// File: rtl/ps2_keycode_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_keycode_receiver
// Function : PS/2 keyboard frame receiver. Emits one-cycle make codes and
//            suppresses E0/F0 prefixes and key releases. A frame stalled
//            mid-way is dropped with an error pulse.
//            Optional parity checking when PS2_PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keycode_receiver #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard,
  output logic       extended,
  output logic       frame_error
);

  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t             r_state, w_next;
  logic               r_clk_meta, r_clk_sync, r_clk_prev;
  logic               r_dat_meta, r_dat_sync;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_shift;
  logic [c_tmo_w-1:0] r_tmo;
  logic               r_done, r_stop;
  logic               r_ext, r_brk;
  logic               w_fall, w_timeout, w_par_ok;

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tmo == c_tmo_last);

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  // Odd parity: data bits together with the parity bit must XOR to 1.
  assign w_par_ok = ^{r_shift, r_parity};
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_sync) w_next = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_dat_meta  <= 1'b1;
      r_dat_sync  <= 1'b1;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_tmo       <= '0;
      r_done      <= 1'b0;
      r_stop      <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      keyboard    <= 8'h00;
      extended    <= 1'b0;
      frame_error <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
      r_state    <= w_next;

      if (r_state == S_IDLE || w_fall || w_timeout) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;

      if (r_state == S_IDLE) begin
        r_bitcnt <= 3'd0;
      end else if (w_fall && r_state == S_DATA) begin
        r_shift  <= {r_dat_sync, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end

`ifdef PS2_PARITY_CHECK_EN
      if (w_fall && r_state == S_PARITY) r_parity <= r_dat_sync;
`endif

      // Stop bit captured here; the byte is decoded one cycle later.
      r_done <= w_fall && (r_state == S_STOP) && !w_timeout;
      r_stop <= r_dat_sync;

      keyboard    <= 8'h00;
      extended    <= 1'b0;
      frame_error <= w_timeout;

      if (r_done) begin
        if (!r_stop || !w_par_ok) begin
          frame_error <= 1'b1;
        end else if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (r_shift != 8'h00) begin
          if (!r_brk) begin
            keyboard <= r_shift;
            extended <= r_ext;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keycode_receiver
// Function : Directed self-checking bench for ps2_keycode_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_receiver;

  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboard;
  logic       extended;
  logic       frame_error;

  int n_vec = 0;
  int n_err = 0;

  ps2_keycode_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keyboard    (keyboard),
    .extended    (extended),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Output monitor: cumulative event counts sampled on the falling clk edge.
  int         cyc = 0;
  int         kb_pulses = 0;
  int         err_pulses = 0;
  int         wide = 0;
  int         orphan_ext = 0;
  int         last_err_cyc = 0;
  logic [7:0] last_kb = 8'h00;
  logic       last_ext = 1'b0;
  logic [7:0] prev_kb = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (keyboard != 8'h00 && prev_kb == 8'h00) begin
      kb_pulses = kb_pulses + 1;
      last_kb   = keyboard;
      last_ext  = extended;
    end
    if (keyboard != 8'h00 && prev_kb != 8'h00) wide = wide + 1;
    if (extended && keyboard == 8'h00) orphan_ext = orphan_ext + 1;
    if (frame_error) begin
      err_pulses   = err_pulses + 1;
      last_err_cyc = cyc;
    end
    prev_kb = keyboard;
  end

  int s_pulses = 0;
  int s_errs = 0;
  int last_fall_cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_pulses = kb_pulses;
    s_errs   = err_pulses;
  endtask

  task automatic expect_result(input string tag, input int pulses,
                               input logic [7:0] kb, input logic ext, input int errs);
    check({tag, "/pulses"}, kb_pulses - s_pulses, pulses);
    if (pulses > 0) begin
      check({tag, "/keyboard"}, int'(last_kb), int'(kb));
      check({tag, "/extended"}, int'(last_ext), int'(ext));
    end
    check({tag, "/frame_error"}, err_pulses - s_errs, errs);
    snap();
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic badpar,
                                     input logic badstop);
    return {~badstop, (~(^d)) ^ badpar, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic badpar = 1'b0,
                            input logic badstop = 1'b0);
    send_bits(mk(d, badpar, badstop), 11);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int lat;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset/keyboard", int'(keyboard), 0);
    check("reset/extended", int'(extended), 0);
    check("reset/frame_error", int'(frame_error), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    snap();

    send_frame(8'h74);
    expect_result("plain74", 1, 8'h74, 1'b0, 0);

    send_frame(8'hE0);
    send_frame(8'h75);
    expect_result("ext75", 1, 8'h75, 1'b1, 0);

    send_frame(8'hF0);
    send_frame(8'h74);
    expect_result("break74", 0, 8'h00, 1'b0, 0);
    send_frame(8'h6B);
    expect_result("after_break6B", 1, 8'h6B, 1'b0, 0);

    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h72);
    expect_result("ext_break72", 0, 8'h00, 1'b0, 0);
    send_frame(8'h72);
    expect_result("plain72", 1, 8'h72, 1'b0, 0);

    send_frame(8'h6B, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    expect_result("badpar6B", 0, 8'h00, 1'b0, 1);
`else
    expect_result("badpar6B", 1, 8'h6B, 1'b0, 0);
`endif

    // A 00 byte between E0 and the code must not disturb the ext flag.
    send_frame(8'hE0);
    send_frame(8'h00);
    send_frame(8'h75);
    expect_result("zero_keeps_ext", 1, 8'h75, 1'b1, 0);

    send_frame(8'h74, 1'b0, 1'b1);
    expect_result("badstop", 0, 8'h00, 1'b0, 1);

    // Falling edge with data high while idle is noise.
    send_bits(11'h7FF, 1);
    repeat (TMO + 20) @(negedge clk);
    expect_result("idle_noise", 0, 8'h00, 1'b0, 0);
    send_frame(8'h74);
    expect_result("after_noise74", 1, 8'h74, 1'b0, 0);

    // Stalled frame: start + 4 data bits, then ps2_clk held high.
    send_bits(mk(8'h75, 1'b0, 1'b0), 5);
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      if (err_pulses != s_errs) break;
    end
    lat = (err_pulses != s_errs) ? (last_err_cyc - last_fall_cyc) : -1;
    check("timeout/latency_in_window", int'(lat >= TMO && lat <= TMO + 6), 1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    expect_result("timeout", 0, 8'h00, 1'b0, 1);
    send_frame(8'h75);
    expect_result("after_timeout75", 1, 8'h75, 1'b0, 0);

    // Reset in the middle of a frame.
    send_bits(mk(8'h74, 1'b0, 1'b0), 6);
    reset_n = 1'b0;
    #1;
    check("midreset/keyboard", int'(keyboard), 0);
    check("midreset/extended", int'(extended), 0);
    check("midreset/frame_error", int'(frame_error), 0);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (TMO + 20) @(negedge clk);
    expect_result("midreset", 0, 8'h00, 1'b0, 0);
    send_frame(8'h74);
    expect_result("after_reset74", 1, 8'h74, 1'b0, 0);

    check("pulse_width_one_cycle", wide, 0);
    check("extended_without_key", orphan_ext, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
